// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode stage between the IF and EX pipeline
// registers. It decodes one instruction per beat, stalls fetch on load-use
// hazards against EX, and counts the stall cycles.
// Optional macro DECODE_M_EXT_EN: when defined, R-type funct7=0000001
// (M extension) decodes as a legal mul/div beat; otherwise it is illegal.
`timescale 1ns/1ps
module decode_stage #(
  parameter int XLEN        = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instr,
  input  logic [XLEN-1:0]        in_pc,
  input  logic                   flush,
  input  logic                   ex_mem_read,
  input  logic [4:0]             ex_rd,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [4:0]             out_rd,
  output logic [4:0]             out_rs1,
  output logic [4:0]             out_rs2,
  output logic [XLEN-1:0]        out_imm,
  output logic [3:0]             out_alu_op,
  output logic                   out_alu_src,
  output logic                   out_reg_write,
  output logic                   out_mem_read,
  output logic                   out_mem_write,
  output logic                   out_branch,
  output logic                   out_jump,
  output logic [1:0]             out_mem_size,
  output logic                   out_mem_unsigned,
  output logic [1:0]             out_result_src,
  output logic [2:0]             out_funct3,
  output logic                   out_illegal,
  output logic                   out_muldiv,
  output logic [2:0]             out_muldiv_op,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_PASS = 4'b1001;

  localparam logic [1:0] MEM_WORD = 2'b10;
  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_MEM  = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu_op;
    logic            alu_src;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic [1:0]      mem_size;
    logic            mem_unsigned;
    logic [1:0]      result_src;
    logic [2:0]      funct3;
    logic            illegal;
    logic            muldiv;
    logic [2:0]      muldiv_op;
  } dec_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1;
  logic [4:0] rs2;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = XLEN'($signed(in_instr[31:20]));
  assign imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                 in_instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                 in_instr[30:21], 1'b0}));

  dec_t dec;
  logic uses_rs1;
  logic uses_rs2;

  // Decode the incoming instruction word into the payload that will be registered.
  always_comb begin
    dec          = '0;
    dec.pc       = in_pc;
    dec.rd       = in_instr[11:7];
    dec.rs1      = rs1;
    dec.rs2      = rs2;
    dec.funct3   = funct3;
    dec.alu_op   = ALU_ADD;
    dec.mem_size = MEM_WORD;
    uses_rs1     = 1'b0;
    uses_rs2     = 1'b0;
    case (opcode)
      OPC_LUI: begin
        dec.imm       = imm_u;
        dec.alu_op    = ALU_PASS;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        dec.imm       = imm_u;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      OPC_JAL: begin
        dec.imm        = imm_j;
        dec.alu_src    = 1'b1;
        dec.jump       = 1'b1;
        dec.reg_write  = 1'b1;
        dec.result_src = RES_PC4;
      end
      OPC_JALR: begin
        uses_rs1       = 1'b1;
        dec.imm        = imm_i;
        dec.alu_src    = 1'b1;
        dec.jump       = 1'b1;
        dec.reg_write  = 1'b1;
        dec.result_src = RES_PC4;
        dec.illegal    = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b1;
        dec.imm     = imm_b;
        dec.alu_op  = ALU_SUB;
        dec.branch  = 1'b1;
        dec.illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPC_LOAD: begin
        uses_rs1         = 1'b1;
        dec.imm          = imm_i;
        dec.alu_src      = 1'b1;
        dec.mem_read     = 1'b1;
        dec.reg_write    = 1'b1;
        dec.result_src   = RES_MEM;
        dec.mem_size     = funct3[1:0];
        dec.mem_unsigned = funct3[2];
        dec.illegal      = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
        dec.imm       = imm_s;
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        dec.mem_size  = funct3[1:0];
        dec.illegal   = (funct3 > 3'b010);
      end
      OPC_OPIMM: begin
        uses_rs1      = 1'b1;
        dec.imm       = imm_i;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = {1'b0, funct3};
        if (funct3 == 3'b001) begin
          dec.illegal = (funct7 != 7'b0000000);
        end else if (funct3 == 3'b101) begin
          if (funct7 == 7'b0100000) begin
            dec.alu_op = ALU_SRA;
          end else if (funct7 != 7'b0000000) begin
            dec.illegal = 1'b1;
          end
        end
      end
      OPC_OP: begin
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
        dec.reg_write = 1'b1;
        if (funct7 == 7'b0000000) begin
          dec.alu_op = {1'b0, funct3};
        end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          dec.alu_op = {1'b1, funct3};
`ifdef DECODE_M_EXT_EN
        end else if (funct7 == 7'b0000001) begin
          dec.muldiv    = 1'b1;
          dec.muldiv_op = funct3;
          dec.alu_op    = ALU_ADD;
`endif
        end else begin
          dec.illegal = 1'b1;
        end
      end
      default: dec.illegal = 1'b1;
    endcase
    // An illegal beat still travels down the pipe but must not cause side effects.
    if (dec.illegal) begin
      dec.reg_write = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
      dec.branch    = 1'b0;
      dec.jump      = 1'b0;
      dec.muldiv    = 1'b0;
    end
  end

  logic                   out_valid_q, out_valid_d;
  dec_t                   payload_q, payload_d;
  logic [STALL_CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic                   hazard;
  logic                   out_free;
  logic                   accept;

  assign hazard = in_valid & ex_mem_read & (ex_rd != 5'd0) &
                  (((ex_rd == rs1) & uses_rs1) | ((ex_rd == rs2) & uses_rs2));
  assign out_free = ~out_valid_q | out_ready;
  assign in_ready = out_free & ~hazard & ~flush;
  assign accept   = in_valid & in_ready;

  // Next-state for the output slot and the stall counter; flush beats everything.
  always_comb begin
    out_valid_d    = out_valid_q;
    payload_d      = payload_q;
    stall_cycles_d = stall_cycles_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (out_free) begin
      out_valid_d = in_valid & ~hazard;
    end
    if (accept) begin
      payload_d = dec;
    end
    if (hazard && !flush && !(&stall_cycles_q)) begin
      stall_cycles_d = stall_cycles_q + STALL_CNT_W'(1);
    end
  end

  // Output register and stall counter, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q        <= 1'b0;
      payload_q          <= '0;
      payload_q.mem_size <= MEM_WORD;
      payload_q.alu_op   <= ALU_ADD;
      stall_cycles_q     <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      payload_q      <= payload_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign out_valid        = out_valid_q;
  assign out_pc           = payload_q.pc;
  assign out_rd           = payload_q.rd;
  assign out_rs1          = payload_q.rs1;
  assign out_rs2          = payload_q.rs2;
  assign out_imm          = payload_q.imm;
  assign out_alu_op       = payload_q.alu_op;
  assign out_alu_src      = payload_q.alu_src;
  assign out_reg_write    = payload_q.reg_write;
  assign out_mem_read     = payload_q.mem_read;
  assign out_mem_write    = payload_q.mem_write;
  assign out_branch       = payload_q.branch;
  assign out_jump         = payload_q.jump;
  assign out_mem_size     = payload_q.mem_size;
  assign out_mem_unsigned = payload_q.mem_unsigned;
  assign out_result_src   = payload_q.result_src;
  assign out_funct3       = payload_q.funct3;
  assign out_illegal      = payload_q.illegal;
  assign out_muldiv       = payload_q.muldiv;
  assign out_muldiv_op    = payload_q.muldiv_op;
  assign stall_cycles     = stall_cycles_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized bench for decode_stage with an
// instruction-level reference model. Honours DECODE_M_EXT_EN like the design.
`timescale 1ns/1ps
module tb_decode_stage;

  localparam int STALL_W   = 4;
  localparam int STALL_MAX = 15;

  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_LUI  = 32'h12345237;
  localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;
  localparam logic [31:0] I_ADD  = 32'h001101B3;
  localparam logic [31:0] I_MUL  = 32'h027302B3;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [31:0]        in_instr = 32'h0;
  logic [31:0]        in_pc = 32'h0;
  logic               flush = 1'b0;
  logic               ex_mem_read = 1'b0;
  logic [4:0]         ex_rd = 5'd0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [31:0]        out_pc;
  logic [4:0]         out_rd, out_rs1, out_rs2;
  logic [31:0]        out_imm;
  logic [3:0]         out_alu_op;
  logic               out_alu_src, out_reg_write, out_mem_read, out_mem_write;
  logic               out_branch, out_jump, out_mem_unsigned, out_illegal, out_muldiv;
  logic [1:0]         out_mem_size, out_result_src;
  logic [2:0]         out_funct3, out_muldiv_op;
  logic [STALL_W-1:0] stall_cycles;

  decode_stage #(.XLEN(32), .STALL_CNT_W(STALL_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_alu_op(out_alu_op), .out_alu_src(out_alu_src), .out_reg_write(out_reg_write),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .out_branch(out_branch),
    .out_jump(out_jump), .out_mem_size(out_mem_size), .out_mem_unsigned(out_mem_unsigned),
    .out_result_src(out_result_src), .out_funct3(out_funct3), .out_illegal(out_illegal),
    .out_muldiv(out_muldiv), .out_muldiv_op(out_muldiv_op), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic        alu_src, reg_write, mem_read, mem_write, branch, jump;
    logic        mem_unsigned, illegal, muldiv, u1, u2, is_mem;
    logic [1:0]  mem_size, result_src;
    logic [2:0]  muldiv_op;
  } ref_t;

  function automatic logic [3:0] alu_code(input int f3, input bit alt);
    case (f3)
      0: return alt ? 4'b1000 : 4'b0000;
      1: return 4'b0001;
      2: return 4'b0010;
      3: return 4'b0011;
      4: return 4'b0100;
      5: return alt ? 4'b1101 : 4'b0101;
      6: return 4'b0110;
      default: return 4'b0111;
    endcase
  endfunction

  // Instruction-level reference: classify by mnemonic group, then apply the rules.
  function automatic ref_t ref_decode(input logic [31:0] ins);
    ref_t r;
    int s, sgn, f3, f7, t;
    int b7, b11_8, b30_25, b11_7, b19_12, b20, b30_21;
    s = ins; f3 = ins[14:12]; f7 = ins[31:25];
    b7 = ins[7]; b11_8 = ins[11:8]; b30_25 = ins[30:25]; b11_7 = ins[11:7];
    b19_12 = ins[19:12]; b20 = ins[20]; b30_21 = ins[30:21];
    sgn = s >>> 31;
    r = '{default: 0};
    r.mem_size = 2'b10;
    case (ins[6:0])
      7'h37: begin r.imm = ins & 32'hFFFFF000; r.alu_op = 4'b1001; r.alu_src = 1; r.reg_write = 1; end
      7'h17: begin r.imm = ins & 32'hFFFFF000; r.alu_src = 1; r.reg_write = 1; end
      7'h6F: begin
        t = sgn * 1048576 + b19_12 * 4096 + b20 * 2048 + b30_21 * 2;
        r.imm = t; r.alu_src = 1; r.jump = 1; r.reg_write = 1; r.result_src = 2'b10;
      end
      7'h67: begin
        t = s >>> 20;
        r.u1 = 1; r.imm = t; r.alu_src = 1; r.jump = 1; r.reg_write = 1; r.result_src = 2'b10;
        r.illegal = (f3 != 0);
      end
      7'h63: begin
        t = sgn * 4096 + b7 * 2048 + b30_25 * 32 + b11_8 * 2;
        r.u1 = 1; r.u2 = 1; r.imm = t; r.alu_op = 4'b1000; r.branch = 1;
        r.illegal = (f3 == 2 || f3 == 3);
      end
      7'h03: begin
        t = s >>> 20;
        r.u1 = 1; r.imm = t; r.alu_src = 1; r.mem_read = 1; r.reg_write = 1; r.result_src = 2'b01;
        r.is_mem = 1; r.mem_size = 2'(f3 % 4); r.mem_unsigned = (f3 >= 4);
        r.illegal = (f3 == 3 || f3 == 6 || f3 == 7);
      end
      7'h23: begin
        t = (s >>> 25) * 32 + b11_7;
        r.u1 = 1; r.u2 = 1; r.imm = t; r.alu_src = 1; r.mem_write = 1;
        r.is_mem = 1; r.mem_size = 2'(f3 % 4); r.illegal = (f3 > 2);
      end
      7'h13: begin
        t = s >>> 20;
        r.u1 = 1; r.imm = t; r.alu_src = 1; r.reg_write = 1;
        r.alu_op = alu_code(f3, (f3 == 5) && (f7 == 32));
        r.illegal = ((f3 == 1) && (f7 != 0)) || ((f3 == 5) && (f7 != 0) && (f7 != 32));
      end
      7'h33: begin
        r.u1 = 1; r.u2 = 1; r.reg_write = 1;
        if (f7 == 0) r.alu_op = alu_code(f3, 0);
        else if (f7 == 32 && (f3 == 0 || f3 == 5)) r.alu_op = alu_code(f3, 1);
`ifdef DECODE_M_EXT_EN
        else if (f7 == 1) begin r.muldiv = 1; r.muldiv_op = 3'(f3); end
`endif
        else r.illegal = 1;
      end
      default: r.illegal = 1;
    endcase
    if (r.illegal) begin
      r.reg_write = 0; r.mem_read = 0; r.mem_write = 0;
      r.branch = 0; r.jump = 0; r.muldiv = 0;
    end
    return r;
  endfunction

  // Model state: what the output slot must hold.
  logic        exp_valid = 1'b0;
  int          exp_stall = 0;
  logic [31:0] exp_instr = 32'h0;
  logic [31:0] exp_pc = 32'h0;
  ref_t        exp_ref;

  function automatic bit model_hazard();
    ref_t r;
    r = ref_decode(in_instr);
    return in_valid && ex_mem_read && (ex_rd != 0) &&
           ((ex_rd == in_instr[19:15] && r.u1) || (ex_rd == in_instr[24:20] && r.u2));
  endfunction

  function automatic bit model_in_ready();
    return (!exp_valid || out_ready) && !model_hazard() && !flush;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_valid <= 1'b0;
      exp_stall <= 0;
    end else begin
      if (model_hazard() && !flush && exp_stall < STALL_MAX) exp_stall <= exp_stall + 1;
      if (flush) exp_valid <= 1'b0;
      else if (!exp_valid || out_ready) begin
        if (in_valid && !model_hazard()) begin
          exp_valid <= 1'b1;
          exp_instr <= in_instr;
          exp_pc    <= in_pc;
          exp_ref   <= ref_decode(in_instr);
        end else begin
          exp_valid <= 1'b0;
        end
      end
    end
  end

  // Compare process: every negedge out of reset.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("in_ready", in_ready, model_in_ready());
        check("out_valid", out_valid, exp_valid);
        check("stall_cycles", stall_cycles, exp_stall);
        if (exp_valid) begin
          check("out_pc", out_pc, exp_pc);
          check("out_rd", out_rd, exp_instr[11:7]);
          check("out_rs1", out_rs1, exp_instr[19:15]);
          check("out_rs2", out_rs2, exp_instr[24:20]);
          check("out_funct3", out_funct3, exp_instr[14:12]);
          check("out_illegal", out_illegal, exp_ref.illegal);
          check("out_reg_write", out_reg_write, exp_ref.reg_write);
          check("out_mem_read", out_mem_read, exp_ref.mem_read);
          check("out_mem_write", out_mem_write, exp_ref.mem_write);
          check("out_branch", out_branch, exp_ref.branch);
          check("out_jump", out_jump, exp_ref.jump);
          check("out_muldiv", out_muldiv, exp_ref.muldiv);
          check("out_muldiv_op", out_muldiv_op, exp_ref.muldiv_op);
          if (!exp_ref.illegal) begin
            check("out_imm", out_imm, exp_ref.imm);
            check("out_alu_op", out_alu_op, exp_ref.alu_op);
            check("out_alu_src", out_alu_src, exp_ref.alu_src);
            check("out_result_src", out_result_src, exp_ref.result_src);
            if (exp_ref.is_mem) begin
              check("out_mem_size", out_mem_size, exp_ref.mem_size);
              check("out_mem_unsigned", out_mem_unsigned, exp_ref.mem_unsigned);
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 11))
      0: w[6:0] = 7'h37;
      1: w[6:0] = 7'h17;
      2: w[6:0] = 7'h6F;
      3: w[6:0] = 7'h67;
      4: w[6:0] = 7'h63;
      5: w[6:0] = 7'h03;
      6: w[6:0] = 7'h23;
      7, 8: w[6:0] = 7'h13;
      9, 10: w[6:0] = 7'h33;
      default: ;
    endcase
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      2: w[31:25] = 7'h01;
      default: ;
    endcase
    w[19:18] = 2'b00;
    w[24:23] = 2'b00;
    return w;
  endfunction

  task automatic offer(input logic [31:0] ins, input logic [31:0] pc);
    @(posedge clk); #1;
    in_valid = 1'b1; in_instr = ins; in_pc = pc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // Reset held with a beat offered.
    in_valid = 1'b1; in_instr = I_ADDI; in_pc = 32'h100; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_stall", stall_cycles, 0);
    check("rst_mem_size", out_mem_size, 2'b10);
    check("rst_alu_op", out_alu_op, 4'b0000);
    @(posedge clk); #1 rst = 1'b0;
    #1 check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    check("addi_latency", out_valid, 0);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("addi_valid", out_valid, 1);
    check("addi_rd", out_rd, 1);
    check("addi_imm", out_imm, 5);
    check("addi_alu_op", out_alu_op, 4'b0000);
    check("addi_alu_src", out_alu_src, 1);
    check("addi_reg_write", out_reg_write, 1);
    check("addi_pc", out_pc, 32'h100);

    offer(I_LUI, 32'h104);
    check("lui_rd", out_rd, 4);
    check("lui_imm", out_imm, 32'h12345000);
    check("lui_alu_op", out_alu_op, 4'b1001);
    check("lui_reg_write", out_reg_write, 1);

    offer(I_BAD, 32'h108);
    check("bad_illegal", out_illegal, 1);
    check("bad_enables", {out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump, out_muldiv}, 0);

    // Load-use hazard on rs1 for two cycles.
    @(posedge clk); #1;
    in_valid = 1'b1; in_instr = I_ADD; in_pc = 32'h10C; ex_mem_read = 1'b1; ex_rd = 5'd2;
    @(negedge clk);
    check("lu_in_ready_0", in_ready, 0);
    @(negedge clk);
    check("lu_in_ready_1", in_ready, 0);
    check("lu_bubble_1", out_valid, 0);
    check("lu_stall_1", stall_cycles, 1);
    @(posedge clk); #1 ex_mem_read = 1'b0;
    @(negedge clk);
    check("lu_bubble_2", out_valid, 0);
    check("lu_stall_2", stall_cycles, 2);
    check("lu_in_ready_free", in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("lu_accept_valid", out_valid, 1);
    check("lu_accept_rd", out_rd, 3);
    check("lu_accept_rs1", out_rs1, 2);

    // Backpressure then flush.
    @(posedge clk); #1;
    in_valid = 1'b1; in_instr = 32'h00A00113; in_pc = 32'h200;
    @(posedge clk); #1;
    out_ready = 1'b0; in_instr = 32'h00B00193; in_pc = 32'h204;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_rd", out_rd, 2);
      check("bp_imm", out_imm, 10);
      check("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1 flush = 1'b1;
    @(negedge clk);
    check("fl_in_ready", in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("fl_out_valid", out_valid, 0);
    @(negedge clk);
    check("fl_dropped", out_valid, 0);

    offer(I_MUL, 32'h300);
    check("mul_rd", out_rd, 5);
`ifdef DECODE_M_EXT_EN
    check("mul_muldiv", out_muldiv, 1);
    check("mul_op", out_muldiv_op, 3'b000);
    check("mul_illegal", out_illegal, 0);
    check("mul_reg_write", out_reg_write, 1);
`else
    check("mul_illegal", out_illegal, 1);
    check("mul_muldiv", out_muldiv, 0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      in_valid    = ($urandom_range(0, 9) < 7);
      in_instr    = rand_instr();
      in_pc       = $urandom;
      out_ready   = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 19) == 0);
      ex_mem_read = ($urandom_range(0, 9) < 3);
      ex_rd       = 5'($urandom_range(0, 7));
    end

    // Asynchronous reset mid-operation drops a pending beat.
    @(posedge clk); #1;
    in_valid = 1'b1; in_instr = I_ADDI; in_pc = 32'h400;
    out_ready = 1'b1; flush = 1'b0; ex_mem_read = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("mid_pending", out_valid, 1);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_stall", stall_cycles, 0);
    check("mid_rst_rd", out_rd, 0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b1; in_instr = I_ADD; ex_mem_read = 1'b1; ex_rd = 5'd2;
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("flush_hz_no_count", stall_cycles, 0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("stall_saturate", stall_cycles, 15);
    check("sat_in_ready", in_ready, 0);
    check("sat_out_valid", out_valid, 0);

    @(posedge clk); #1;
    in_valid = 1'b0; ex_mem_read = 1'b0;
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
